// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 types, command bytes and time conversion
package ps2_pkg;
  typedef enum logic [2:0] {
    IDLE, INHIBIT, REQ, DATA, PARITY, STOP, ACK, RELEASE
  } ps2_tx_state_e;
  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  // 64-bit product so 15 ms at 50 MHz and similar do not overflow
  function automatic logic [31:0] us_to_cycles(input int unsigned clk_hz, input int unsigned us);
    return 32'((64'(clk_hz) * 64'(us)) / 64'd1_000_000);
  endfunction
endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-flop synchronizer, FILT_LEN-sample glitch filter, falling-edge flag
//   clk_i   system clock
//   rst_ni  async active-low reset; line assumed idle high
//   raw_i   raw pad level
//   level_o filtered level
//   fall_o  one-cycle pulse on a filtered 1->0 transition
module ps2_line_filter #(
  parameter int unsigned FILT_LEN = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o,
  output logic fall_o
);
  logic [1:0] sync_q;
  logic [FILT_LEN-1:0] hist_q;
  logic level_q, level_d, fall_q;
  assign level_d = &hist_q ? 1'b1 : ~|hist_q ? 1'b0 : level_q;
  assign level_o = level_q;
  assign fall_o = fall_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '1;
      hist_q <= '1;
      level_q <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      hist_q <= {hist_q[FILT_LEN-2:0], sync_q[1]};
      level_q <= level_d;
      fall_q <= level_q & ~level_d;
    end
  end
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter
//   CLOCK_50 / RESET_N        system clock, async active-low reset
//   tx_valid/tx_data/tx_ready byte handshake, accepted only when idle
//   tx_done / tx_err          one-cycle result pulses (ACK seen / timeout or no ACK)
//   ps2_clk_in / ps2_dat_in   raw pad levels
//   ps2_clk_oe / ps2_dat_oe   1 = pull pad low, 0 = release
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned INHIBIT_US = 120,
  parameter int unsigned TIMEOUT_US = 15000,
  parameter int unsigned FILT_LEN   = 8
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);
  localparam logic [31:0] INH_CYC = us_to_cycles(CLK_HZ, INHIBIT_US);
  localparam logic [31:0] TO_CYC  = us_to_cycles(CLK_HZ, TIMEOUT_US);
  localparam logic [31:0] PRE_CYC = us_to_cycles(CLK_HZ, 2);
  ps2_tx_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] data_q, data_d;
  logic [31:0] tmr_q, tmr_d;
  logic par_q, par_d, clk_oe_q, clk_oe_d, dat_oe_q, dat_oe_d, done_q, done_d, err_q, err_d;
  logic clk_lvl, clk_fall, dat_lvl, dat_fall_unused, busy;
  ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_clk_filt (
    .clk_i(CLOCK_50), .rst_ni(RESET_N), .raw_i(ps2_clk_in), .level_o(clk_lvl), .fall_o(clk_fall)
  );
  ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_dat_filt (
    .clk_i(CLOCK_50), .rst_ni(RESET_N), .raw_i(ps2_dat_in), .level_o(dat_lvl), .fall_o(dat_fall_unused)
  );
  // device-paced states: clock edges count and the timeout is armed
  assign busy = (state_q != IDLE) && (state_q != INHIBIT);
  assign tx_ready = state_q == IDLE;
  assign tx_done = done_q;
  assign tx_err = err_q;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    data_d = data_q;
    par_d = par_q;
    done_d = 1'b0;
    err_d = 1'b0;
    case (state_q)
      IDLE: if (tx_valid) begin
        state_d = INHIBIT;
        data_d = tx_data;
        par_d = ~^tx_data;
      end
      INHIBIT: if (tmr_q == '0) state_d = REQ;
      REQ: if (clk_fall) begin
        state_d = DATA;
        cnt_d = '0;
      end
      DATA: if (clk_fall) begin
        cnt_d = cnt_q + 3'd1;
        state_d = (cnt_q == 3'd7) ? PARITY : DATA;
      end
      PARITY: if (clk_fall) state_d = STOP;
      // device samples the stop bit on its rising edge; ACK edge follows
      STOP: if (clk_lvl) state_d = ACK;
      ACK: if (clk_fall) begin
        state_d = dat_lvl ? IDLE : RELEASE;
        err_d = dat_lvl;
      end
      RELEASE: if (clk_lvl && dat_lvl) begin
        state_d = IDLE;
        done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (busy && tmr_q == '0) begin
      state_d = IDLE;
      done_d = 1'b0;
      err_d = 1'b1;
    end
    // one down-counter times both the inhibit period and the device timeout
    tmr_d = (state_d != state_q || (busy && clk_fall)) ? ((state_d == INHIBIT) ? INH_CYC - 32'd1 : TO_CYC - 32'd1)
          : (tmr_q == '0) ? '0 : tmr_q - 32'd1;
    clk_oe_d = state_d == INHIBIT;
    dat_oe_d = (state_d == INHIBIT) ? (tmr_d < PRE_CYC)
             : (state_d == REQ) ? 1'b1
             : (state_d == DATA) ? ~data_q[cnt_d]
             : (state_d == PARITY) ? ~par_q : 1'b0;
  end
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      cnt_q <= '0;
      data_q <= '0;
      par_q <= 1'b0;
      tmr_q <= '0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      par_q <= par_d;
      tmr_q <= tmr_d;
      clk_oe_q <= clk_oe_d;
      dat_oe_q <= dat_oe_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: scoreboard bench with a PS/2 device model (1 MHz clock scale, 80-cycle device clock)
module tb_ps2_host_tx;
  logic CLOCK_50 = 1'b0, RESET_N = 1'b0, tx_valid = 1'b0;
  logic [7:0] tx_data = '0;
  logic tx_ready, tx_done, tx_err, ps2_clk_oe, ps2_dat_oe;
  logic dev_clk = 1'b1, dev_dat = 1'b1;
  logic ps2_clk_in, ps2_dat_in;
  int n_cmp = 0, n_fail = 0;
  typedef struct packed {logic ok; logic has_frame; logic [9:0] frame;} exp_t;
  exp_t exp_q[$];
  logic [9:0] got_q[$];
  exp_t e;
  logic [9:0] gf;
  assign ps2_clk_in = ~ps2_clk_oe & dev_clk;
  assign ps2_dat_in = ~ps2_dat_oe & dev_dat;
  always #5 CLOCK_50 = ~CLOCK_50;
  ps2_host_tx #(.CLK_HZ(1_000_000), .INHIBIT_US(120), .TIMEOUT_US(15000), .FILT_LEN(8)) dut (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .tx_done(tx_done), .tx_err(tx_err),
    .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in), .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe)
  );
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, want, $time);
    end
  endtask
  always @(negedge CLOCK_50) begin
    if (tx_done || tx_err) begin
      chk("done_err_exclusive", 32'(tx_done & tx_err), 0);
      if (exp_q.size() == 0) chk("unexpected_pulse", {30'b0, tx_done, tx_err}, 0);
      else begin
        e = exp_q.pop_front();
        chk("outcome_done", 32'(tx_done), 32'(e.ok));
        chk("outcome_err", 32'(tx_err), 32'(!e.ok));
        if (e.has_frame) begin
          chk("frame_present", got_q.size(), 1);
          if (got_q.size() > 0) begin
            gf = got_q.pop_front();
            chk("frame_bits", 32'(gf), 32'(e.frame));
          end
        end
      end
    end
  end
  task automatic send(input logic [7:0] d);
    int ci, cd;
    @(negedge CLOCK_50);
    tx_data = d;
    tx_valid = 1'b1;
    @(negedge CLOCK_50);
    chk("accept_clk_oe", 32'(ps2_clk_oe), 1);
    chk("busy_not_ready", 32'(tx_ready), 0);
    tx_data = 8'h55;
    ci = 0;
    cd = 0;
    while (ps2_clk_oe && ci < 1000) begin
      ci++;
      cd += int'(ps2_dat_oe);
      @(negedge CLOCK_50);
    end
    tx_valid = 1'b0;
    chk("inhibit_cycles", ci, 120);
    chk("inhibit_dat_low_cycles", cd, 2);
    chk("start_bit_dat_oe", 32'(ps2_dat_oe), 1);
  endtask
  task automatic dev_xfer(input bit ack, input int abort_at, input bit glitch, output bit aborted);
    logic [9:0] f;
    int n;
    f = '0;
    aborted = 1'b0;
    n = 0;
    while (!(ps2_dat_oe && !ps2_clk_oe) && n < 2000) begin
      @(negedge CLOCK_50);
      n++;
    end
    chk("req_seen", 32'(n < 2000), 1);
    repeat (20) @(negedge CLOCK_50);
    for (int i = 0; i < 11; i++) begin
      if (i == 10) dev_dat = !ack;
      repeat (10) @(negedge CLOCK_50);
      dev_clk = 1'b0;
      repeat (40) @(negedge CLOCK_50);
      dev_clk = 1'b1;
      if (i < 10) f[i] = ps2_dat_in;
      if (i == 9) got_q.push_back(f);
      if (i == abort_at) begin
        aborted = 1'b1;
        return;
      end
      if (i == 10) dev_dat = 1'b1;
      if (glitch && i >= 1 && i <= 6) begin
        repeat (10) @(negedge CLOCK_50);
        dev_clk = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        dev_clk = 1'b1;
        repeat (18) @(negedge CLOCK_50);
      end else repeat (30) @(negedge CLOCK_50);
    end
  endtask
  task automatic wait_idle();
    int n = 0;
    while (!tx_ready && n < 500) begin
      @(negedge CLOCK_50);
      n++;
    end
    chk("ready_after_xfer", 32'(tx_ready), 1);
    repeat (20) @(negedge CLOCK_50);
  endtask
  task automatic run_xfer(input logic [7:0] d, input logic par, input bit glitch, input bit ack);
    bit ab;
    exp_q.push_back('{ok: ack, has_frame: 1'b1, frame: {1'b1, par, d}});
    send(d);
    dev_xfer(ack, -1, glitch, ab);
    wait_idle();
  endtask
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected summary");
    $fatal(1, "watchdog expired");
  end
  initial begin
    bit ab;
    int n;
    repeat (3) @(negedge CLOCK_50);
    chk("rst_ready", 32'(tx_ready), 1);
    chk("rst_oe", {30'b0, ps2_clk_oe, ps2_dat_oe}, 0);
    chk("rst_pulses", {30'b0, tx_done, tx_err}, 0);
    RESET_N = 1'b1;
    repeat (20) @(negedge CLOCK_50);
    chk("post_rst_ready", 32'(tx_ready), 1);
    run_xfer(8'hED, 1'b1, 1'b0, 1'b1);
    run_xfer(8'h00, 1'b1, 1'b0, 1'b1);
    run_xfer(8'h01, 1'b0, 1'b0, 1'b1);
    run_xfer(8'hA5, 1'b1, 1'b1, 1'b1);
    run_xfer(8'hFF, 1'b1, 1'b0, 1'b0);
    exp_q.push_back('{ok: 1'b0, has_frame: 1'b0, frame: '0});
    send(8'h12);
    n = 0;
    while (!tx_err && n < 20000) begin
      @(negedge CLOCK_50);
      n++;
    end
    chk("timeout_cycles", n, 15000);
    chk("timeout_oe", {30'b0, ps2_clk_oe, ps2_dat_oe}, 0);
    chk("timeout_ready", 32'(tx_ready), 1);
    repeat (20) @(negedge CLOCK_50);
    send(8'h5A);
    dev_xfer(1'b1, 3, 1'b0, ab);
    chk("abort_reached", 32'(ab), 1);
    #2 RESET_N = 1'b0;
    #1;
    chk("async_rst_oe", {30'b0, ps2_clk_oe, ps2_dat_oe}, 0);
    chk("async_rst_pulses", {30'b0, tx_done, tx_err}, 0);
    repeat (5) @(negedge CLOCK_50);
    RESET_N = 1'b1;
    repeat (30) @(negedge CLOCK_50);
    chk("rerst_ready", 32'(tx_ready), 1);
    run_xfer(8'hF4, 1'b0, 1'b0, 1'b1);
    repeat (50) @(negedge CLOCK_50);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("frames_drained", got_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
